fir_mac_scheduler: RTL and testbench

- Time-multiplexes one shared 16x16 unsigned dadda_multiplier across all taps of a direct-form FIR used for ECG denoising.
- Accepts one input sample per handshake and stores it in a circular delay line.
- Issues TAPS multiplies serially, one per cycle, and accumulates the products.
- Presents one filtered output sample with a valid/ready handshake.

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_delay_line.sv | 33 +++
 rtl/fir_mac_scheduler.sv | 122 ++++++++++++
 tb/tb_fir_mac_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and index helpers for the time-multiplexed FIR.
package fir_pkg;
  localparam int DATA_W = 16;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, DONE} state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // (base - dec) mod n, for base in [0,n) and dec in [0,n]
  function automatic int mod_dec(input int base, input int dec, input int n);
    return (base >= dec) ? base - dec : base + n - dec;
  endfunction
endpackage

// File: rtl/fir_delay_line.sv
// Circular sample history; read port addressed by age (0 = newest sample).
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int TAPS = 8,
  parameter int DW   = 16,
  localparam int PW  = clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [DW-1:0] din,
  input  logic [PW-1:0] age,
  output logic [DW-1:0] dout
);
  logic [TAPS-1:0][DW-1:0] mem;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
    end else if (we) begin
      mem[wr_ptr] <= din;
      wr_ptr      <= (wr_ptr == PW'(TAPS - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  // wr_ptr points at the next free slot, so the newest sample sits at wr_ptr-1
  assign rd_idx = PW'(mod_dec(int'(wr_ptr), int'(age) + 1, TAPS));
  assign dout   = mem[rd_idx];
endmodule

// File: rtl/fir_mac_scheduler.sv
// Serial FIR: one shared multiplier, TAPS MAC cycles per sample, valid/ready output.
// Optional FIR_ROUND_SAT_EN: round half-up and saturate the output instead of truncating.
module fir_mac_scheduler #(
  parameter int TAPS      = 8,
  parameter int DATA_W    = fir_pkg::DATA_W,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0,
  localparam int AW       = fir_pkg::clog2(TAPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  coef_we,
  input  logic [AW-1:0]         coef_addr,
  input  logic [DATA_W-1:0]     coef_data,
  output logic                  busy,
  output logic [DATA_W-1:0]     mul_a,
  output logic [DATA_W-1:0]     mul_b,
  input  logic [2*DATA_W-1:0]   mul_p,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [OUT_W-1:0]      y_data
);
  import fir_pkg::*;

  localparam int ACC_W = 2 * DATA_W + AW;

  state_t                     state, nxt;
  logic [AW-1:0]              k;
  logic [ACC_W-1:0]           acc;
  logic [2*DATA_W-1:0]        p_reg;
  logic [TAPS-1:0][DATA_W-1:0] coef;
  logic [DATA_W-1:0]          x_k;
  logic [OUT_W-1:0]           y_shaped;
  logic                       accept, last_k;

  assign accept = (state == IDLE) && in_valid;
  assign last_k = (k == AW'(TAPS - 1));

  fir_delay_line #(.TAPS(TAPS), .DW(DATA_W)) u_dl (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .din   (in_data),
    .age   (k),
    .dout  (x_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      acc   <= '0;
      p_reg <= '0;
      coef  <= '0;
    end else begin
      p_reg <= mul_p;
      if (state == IDLE && coef_we && int'(coef_addr) < TAPS)
        coef[coef_addr] <= coef_data;
      case (state)
        IDLE: if (in_valid) begin
          acc <= '0;
          k   <= '0;
        end
        // p_reg lags one cycle, so the first MAC cycle has nothing to add yet
        MAC: begin
          if (k != '0) acc <= acc + ACC_W'(p_reg);
          if (!last_k) k <= k + 1'b1;
        end
        DRAIN: acc <= acc + ACC_W'(p_reg);
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = MAC;
      MAC:     if (last_k)   nxt = DRAIN;
      DRAIN:                 nxt = DONE;
      DONE:    if (y_ready)  nxt = IDLE;
      default:               nxt = IDLE;
    endcase
  end

`ifdef FIR_ROUND_SAT_EN
  localparam logic [ACC_W:0] RND = ((ACC_W+1)'(1) << OUT_SHIFT) >> 1;
  logic [ACC_W:0] rnd_sum;
  assign rnd_sum  = ({1'b0, acc} + RND) >> OUT_SHIFT;
  assign y_shaped = (rnd_sum > (ACC_W+1)'({OUT_W{1'b1}})) ? '1 : rnd_sum[OUT_W-1:0];
`else
  assign y_shaped = OUT_W'(acc >> OUT_SHIFT);
`endif

  always_comb begin
    in_ready = 1'b0;
    busy     = (state != IDLE);
    mul_a    = '0;
    mul_b    = '0;
    y_valid  = 1'b0;
    y_data   = '0;
    case (state)
      IDLE: in_ready = rst_n;
      MAC: begin
        mul_a = x_k;
        mul_b = coef[k];
      end
      DONE: begin
        y_valid = 1'b1;
        y_data  = y_shaped;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Scoreboard bench for fir_mac_scheduler: directed test-plan sequences plus random traffic.
module tb_fir_mac_scheduler;
  localparam int TAPS      = 5;
  localparam int DATA_W    = 16;
  localparam int OUT_W     = 16;
  localparam int OUT_SHIFT = 0;
  localparam int AW        = $clog2(TAPS);

  logic              clk, rst_n;
  logic              in_valid, in_ready, coef_we, busy, y_valid, y_ready;
  logic [DATA_W-1:0] in_data, coef_data, mul_a, mul_b;
  logic [AW-1:0]     coef_addr;
  logic [2*DATA_W-1:0] mul_p;
  logic [OUT_W-1:0]  y_data;

  fir_mac_scheduler #(.TAPS(TAPS), .DATA_W(DATA_W), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .y_valid(y_valid), .y_ready(y_ready),
    .y_data(y_data)
  );

  // the shared multiplier lives outside the block
  assign mul_p = mul_a * mul_b;

  int tests = 0, fails = 0, cyc = 0, last_acc = 0;
  bit rdy_rand = 0, rdy_force = 1, prev_yv = 0;
  longint unsigned q[$];
  longint unsigned hist[TAPS];
  longint unsigned h[TAPS];

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end
  initial forever begin
    @(posedge clk); #1;
    y_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint unsigned shape(input longint unsigned a);
    longint unsigned r;
`ifdef FIR_ROUND_SAT_EN
    r = (a + ((64'd1 << OUT_SHIFT) >> 1)) >> OUT_SHIFT;
    if (r > 64'd65535) r = 64'd65535;
`else
    r = (a >> OUT_SHIFT) & 64'hFFFF;
`endif
    return r;
  endfunction

  // reference: y = sum_k h[k] * x[n-k] over a zero-initialised history
  function automatic void model_accept(input longint unsigned d);
    longint unsigned s = 0;
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = d;
    for (int i = 0; i < TAPS; i++) s += hist[i] * h[i];
    q.push_back(shape(s));
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < TAPS; i++) begin hist[i] = 0; h[i] = 0; end
  endfunction

  // monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (!busy) check("idle_mul_zero", {mul_a, mul_b}, 0);
      if (y_valid) begin
        if (!prev_yv) check("latency_edges", longint'(cyc - last_acc), TAPS + 1);
        check("in_ready_in_done", in_ready, 0);
        if (q.size() == 0) check("unexpected_output", 1, 0);
        else begin
          check("y_data", y_data, q[0]);
          if (y_ready) void'(q.pop_front());
        end
      end
      prev_yv = y_valid;
    end else prev_yv = 0;
  end

  task automatic send(input logic [15:0] d, input bit we, input int addr, input logic [15:0] cd);
    bit done = 0;
    @(posedge clk); #1;
    in_valid = 1; in_data = d; coef_we = we; coef_addr = AW'(addr); coef_data = cd;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        if (we && addr < TAPS) h[addr] = cd;
        model_accept(d);
        last_acc = cyc + 1;
        done = 1;
      end
    end
    if (!done) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0; coef_we = 0;
  endtask

  task automatic wr_coef(input int addr, input logic [15:0] cd);
    @(posedge clk); #1;
    coef_we = 1; coef_addr = AW'(addr); coef_data = cd;
    @(negedge clk);
    if (in_ready && addr < TAPS) h[addr] = cd;
    @(posedge clk); #1;
    coef_we = 0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 2000 && q.size() != 0; n++) @(negedge clk);
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_data = 0; coef_we = 0; coef_addr = 0; coef_data = 0; y_ready = 1;
    model_clear();
    repeat (2) @(posedge clk); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_mul", {mul_a, mul_b}, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_y_data", y_data, 0);
    rst_n = 1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // impulse response
    for (int i = 0; i < TAPS; i++) wr_coef(i, 16'(i + 1));
    send(1, 0, 0, 0);
    for (int i = 0; i < TAPS; i++) send(0, 0, 0, 0);
    wait_drain();

    // large values
    for (int i = 0; i < TAPS; i++) wr_coef(i, 16'hFFFF);
    for (int i = 0; i < TAPS; i++) send(16'hFFFF, 0, 0, 0);
    wait_drain();

    // back-pressure
    rdy_force = 0;
    send(16'd7, 0, 0, 0);
    for (int n = 0; n < 100 && !y_valid; n++) @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      check("bp_y_valid", y_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    rdy_force = 1;
    wait_drain();
    @(negedge clk);
    check("bp_back_idle", in_ready, 1);

    // coefficient writes while busy / out of range / same cycle as a sample
    for (int i = 0; i < TAPS; i++) wr_coef(i, 16'(3 * i + 2));
    send(1, 0, 0, 0);
    wr_coef(0, 16'd9);
    wait_drain();
    send(1, 0, 0, 0);
    wait_drain();
    wr_coef(7, 16'd100);
    wr_coef(1, 16'd11);
    send(2, 1, 0, 16'd13);
    wait_drain();

    // ramp with wrap-around of the delay line
    for (int i = 0; i < TAPS; i++) wr_coef(i, 16'd1);
    for (int i = 1; i <= 12; i++) send(16'(i), 0, 0, 0);
    wait_drain();

    // random traffic with random back-pressure
    rdy_rand = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) wr_coef(int'($urandom_range(0, 7)), 16'($urandom));
      send(16'($urandom), $urandom_range(0, 3) == 0, int'($urandom_range(0, TAPS - 1)), 16'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_drain();
    rdy_rand = 0; rdy_force = 1;

    // reset during MAC k=2
    send(16'd50, 0, 0, 0);
    repeat (2) @(posedge clk); #1;
    check("mac_busy", busy, 1);
    rst_n = 0; #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_mul", {mul_a, mul_b}, 0);
    check("abort_y_valid", y_valid, 0);
    check("abort_y_data", y_data, 0);
    q.delete();
    model_clear();
    repeat (2) @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < TAPS; i++) wr_coef(i, 16'(10 + i));
    send(1, 0, 0, 0);
    for (int i = 0; i < TAPS; i++) send(0, 0, 0, 0);
    wait_drain();

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
